// File: rtl/rr_fifo_push_arbiter.sv
// Round-robin arbiter that shares one FIFO push port among NUM_REQ requesters,
// with a RUN/FLUSH/ACK sequence for flushing the FIFO and restarting arbitration.
module rr_fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_flush_o,
  input  logic                          flush_req_i,
  output logic                          flush_ack_o,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_idx_o,
  output logic [NUM_REQ*8-1:0]          grant_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   gnt_idx_r;
  logic [7:0]         cnt_r [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   gnt_k_s;
  logic               grant_en_s;
  logic               push_s;

  // Next-state, round-robin pick and strobe outputs
  always_comb begin : comb_main
    logic [IDX_W-1:0] idx_v;
    logic             hit_v;
    logic             found_v;
    state_s      = state_r;
    gnt_s        = '0;
    gnt_k_s      = '0;
    idx_v        = '0;
    hit_v        = 1'b0;
    found_v      = 1'b0;
    fifo_flush_o = 1'b0;
    flush_ack_o  = 1'b0;
    case (state_r)
      ST_RUN:   state_s = flush_req_i ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_s = ST_ACK;
      ST_ACK:   state_s = ST_RUN;
      default:  state_s = ST_RUN;
    endcase
    if (!rst_i) begin
      fifo_flush_o = (state_r == ST_FLUSH);
      flush_ack_o  = (state_r == ST_ACK);
    end else begin
      fifo_flush_o = 1'b0;
      flush_ack_o  = 1'b0;
    end
    grant_en_s = (state_r == ST_RUN) && !rst_i && !flush_req_i && !fifo_full_i;
    // Search upward from the pointer; index arithmetic wraps since NUM_REQ is 2^n
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v        = ptr_r + IDX_W'(i);
      hit_v        = grant_en_s && !found_v && req_i[idx_v];
      gnt_s[idx_v] = hit_v;
      gnt_k_s      = hit_v ? idx_v : gnt_k_s;
      found_v      = found_v | hit_v;
    end
    push_s      = |gnt_s;
    gnt_o       = gnt_s;
    fifo_push_o = push_s;
    if (push_s) begin
      fifo_data_o = data_i[gnt_k_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      fifo_data_o = '0;
    end
  end

  // State, priority pointer and last-grant index
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_RUN;
      ptr_r     <= '0;
      gnt_idx_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_ACK) begin
        ptr_r     <= '0;
        gnt_idx_r <= '0;
      end else if (push_s) begin
        ptr_r     <= gnt_k_s + IDX_W'(1);
        gnt_idx_r <= gnt_k_s;
      end else begin
        ptr_r     <= ptr_r;
        gnt_idx_r <= gnt_idx_r;
      end
    end
  end

  // Saturating per-requester grant counters; flush leaves them intact
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rst_i) begin
        cnt_r[k] <= 8'd0;
      end else if (gnt_s[k] && (cnt_r[k] != 8'hFF)) begin
        cnt_r[k] <= cnt_r[k] + 8'd1;
      end else begin
        cnt_r[k] <= cnt_r[k];
      end
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_cnt_o[k*8 +: 8] = cnt_r[k];
    end
  end

  assign gnt_idx_o = gnt_idx_r;

endmodule

// File: tb/tb_rr_fifo_push_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a behavioural arbiter model.
module tb_rr_fifo_push_arbiter;

  localparam int NR = 4;
  localparam int DW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_i;
  logic [NR*DW-1:0] data_i;
  logic [NR-1:0]   gnt_o;
  logic            fifo_full_i;
  logic            fifo_push_o;
  logic [DW-1:0]   fifo_data_o;
  logic            fifo_flush_o;
  logic            flush_req_i;
  logic            flush_ack_o;
  logic [1:0]      gnt_idx_o;
  logic [NR*8-1:0] grant_cnt_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // model: phase 0=run 1=flush 2=ack
  int m_phase;
  int m_ptr;
  int m_idx;
  int m_cnt [NR];

  rr_fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i), .gnt_o(gnt_o),
    .fifo_full_i(fifo_full_i), .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o),
    .fifo_flush_o(fifo_flush_o), .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .gnt_idx_o(gnt_idx_o), .grant_cnt_o(grant_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_k();
    if (rst_i || m_phase != 0 || flush_req_i || fifo_full_i) return -1;
    for (int i = 0; i < NR; i++) begin
      if (req_i[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    end
    return -1;
  endfunction

  // Model update at each rising edge
  always @(posedge clk_i) begin
    int k;
    k = exp_k();
    if (rst_i) begin
      m_phase <= 0; m_ptr <= 0; m_idx <= 0;
      for (int i = 0; i < NR; i++) m_cnt[i] <= 0;
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else if (m_phase == 2) begin
      m_phase <= 0; m_ptr <= 0; m_idx <= 0;
    end else if (flush_req_i) begin
      m_phase <= 1;
    end else if (k >= 0) begin
      m_ptr <= (k + 1) % NR;
      m_idx <= k;
      m_cnt[k] <= (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
    end
  end

  // Compare all outputs against the model mid-cycle
  always @(negedge clk_i) begin
    int k;
    logic [NR-1:0]   eg;
    logic [DW-1:0]   ed;
    logic [NR*8-1:0] ec;
    if (chk_en) begin
      k  = exp_k();
      eg = '0;
      ed = '0;
      if (k >= 0) begin
        eg[k] = 1'b1;
        ed = data_i[k*DW +: DW];
      end
      for (int i = 0; i < NR; i++) ec[i*8 +: 8] = m_cnt[i][7:0];
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("push", 64'(fifo_push_o), 64'(k >= 0));
      chk("data", 64'(fifo_data_o), 64'(ed));
      chk("flush", 64'(fifo_flush_o), 64'(!rst_i && m_phase == 1));
      chk("ack", 64'(flush_ack_o), 64'(!rst_i && m_phase == 2));
      chk("gnt_idx", 64'(gnt_idx_o), 64'(m_idx));
      chk("cnt", 64'(grant_cnt_o), 64'(ec));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    data_i = NR*DW'($urandom);
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; data_i = '0; fifo_full_i = 1'b0; flush_req_i = 1'b0;
    @(posedge clk_i); #1;
    chk_en = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_cnt", 64'(grant_cnt_o), 64'h0);
    chk("rst_idx", 64'(gnt_idx_o), 64'h0);

    // five grants with everyone requesting
    begin
      logic [NR-1:0] seq [5];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        req_i = 4'b1111; #1;
        chk("rr_seq", 64'(gnt_o), 64'(seq[i]));
        step();
      end
    end
    req_i = '0;
    chk("rr_cnt", 64'(grant_cnt_o), 64'h01010102);

    // wrap search from pointer 2
    req_i = 4'b0010; step();
    req_i = 4'b0011; #1;
    chk("wrap_gnt", 64'(gnt_o), 64'h1);
    step();
    chk("wrap_idx", 64'(gnt_idx_o), 64'h0);
    #1;
    chk("wrap_ptr1", 64'(gnt_o), 64'h2);
    req_i = '0;

    // full blocks grant for 3 cycles
    req_i = 4'b0100; fifo_full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("full_gnt", 64'(gnt_o), 64'h0); step();
    end
    fifo_full_i = 1'b0; #1;
    chk("full_rel", 64'(gnt_o), 64'h4);
    step();
    req_i = '0;
    chk("full_cnt2", 64'(grant_cnt_o[23:16]), 64'd2);

    // flush pulse
    req_i = 4'b1111; flush_req_i = 1'b1; #1;
    chk("fl_gnt", 64'(gnt_o), 64'h0);
    step(); flush_req_i = 1'b0; #1;
    chk("fl_flush", 64'(fifo_flush_o), 64'h1);
    chk("fl_gnt2", 64'(gnt_o), 64'h0);
    step(); #1;
    chk("fl_ack", 64'(flush_ack_o), 64'h1);
    step(); #1;
    chk("fl_after", 64'(gnt_o), 64'h1);
    req_i = '0;

    // counter saturation
    req_i = 4'b0010;
    for (int i = 0; i < 300; i++) step();
    req_i = '0;
    chk("sat", 64'(grant_cnt_o[15:8]), 64'd255);
    flush_req_i = 1'b1; step(); flush_req_i = 1'b0; step(); step();
    chk("sat_flush", 64'(grant_cnt_o[15:8]), 64'd255);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("sat_rst", 64'(grant_cnt_o), 64'h0);

    // reset during flush aborts sequence
    req_i = 4'b0010; step();
    req_i = '0; flush_req_i = 1'b1; step();
    flush_req_i = 1'b0; rst_i = 1'b1; #1;
    chk("abort_flush", 64'(fifo_flush_o), 64'h0);
    step(); rst_i = 1'b0; req_i = 4'b1111; #1;
    chk("abort_ack", 64'(flush_ack_o), 64'h0);
    chk("abort_gnt", 64'(gnt_o), 64'h1);
    req_i = '0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      req_i       = NR'($urandom);
      fifo_full_i = ($urandom_range(0, 3) == 0);
      flush_req_i = ($urandom_range(0, 15) == 0);
      rst_i       = ($urandom_range(0, 63) == 0);
      step();
    end
    rst_i = 1'b0; req_i = '0; flush_req_i = 1'b0; fifo_full_i = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
